// File: rtl/v60_prefetch_queue_if.sv
// rtl/v60_prefetch_queue_if.sv - instruction fetch bus between prefetch queue and bus interface
//
// Purpose: carries one word fetch at a time from the prefetch queue to the bus interface.
// Signals:
//   fetch_req   queue -> bus  word fetch request, held until fetch_ack
//   fetch_addr  queue -> bus  word-aligned fetch address, stable while fetch_req is high
//   fetch_ack   bus -> queue  fetch completes this cycle, fetch_data valid
//   fetch_data  bus -> queue  fetched word, little-endian
// Modports: master = prefetch queue, slave = bus interface.

interface v60_prefetch_queue_if;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ack;
  logic [31:0] fetch_data;

  modport master (
    output fetch_req,
    output fetch_addr,
    input  fetch_ack,
    input  fetch_data
  );

  modport slave (
    input  fetch_req,
    input  fetch_addr,
    output fetch_ack,
    output fetch_data
  );
endinterface

// File: rtl/v60_prefetch_queue.sv
// rtl/v60_prefetch_queue.sv - byte-granular instruction prefetch queue with word fetch bus
//
// Purpose: fetches 32-bit words ahead of the decoder into a circular byte buffer and
// presents the next six bytes at the head, with the address of the head byte.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   bus           fetch bus (master side): fetch_req/fetch_addr out, fetch_ack/fetch_data in
//   flush         discard queue and restart fetching at flush_addr (any alignment)
//   flush_addr    new program counter
//   inst          next six queued bytes, head byte in [47:40]; unqueued bytes read as zero
//   inst_valid    at least six bytes queued
//   inst_pc       address of the head byte
//   consume       retire consume_len bytes (ignored unless inst_valid)
//   consume_len   bytes to retire, 1-7 (0 is a no-op)
//   count         bytes currently queued

module v60_prefetch_queue #(
  parameter int unsigned DEPTH    = 16,
  parameter logic [31:0] RESET_PC = 32'hFFFF_FFF0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  v60_prefetch_queue_if.master     bus,
  input  logic                     flush,
  input  logic [31:0]              flush_addr,
  output logic [47:0]              inst,
  output logic                     inst_valid,
  output logic [31:0]              inst_pc,
  input  logic                     consume,
  input  logic [2:0]               consume_len,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

  state_t          state;
  state_t          state_next;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_next;
  logic [31:0]     pc_q;
  logic [31:0]     addr_q;
  logic [1:0]      skip_q;
  logic [7:0]      mem [DEPTH];

  logic            do_write;
  logic [2:0]      wr_len;
  logic            do_retire;
  logic [2:0]      ret_len;
  logic            space_ok;

  // Bytes written by an ack: the leading skip bytes of the first word after a
  // redirect lie below the target address and are dropped.
  always_comb begin
    do_write = (state == FETCH) && bus.fetch_ack;
    wr_len   = 3'd0;
    if (do_write) begin
      wr_len = 3'd4 - {1'b0, skip_q};
    end
  end

  // A retire can only ask for more than is queued when count is exactly 6 and
  // consume_len is 7, so clamping through count_q[2:0] is exact.
  always_comb begin
    do_retire = consume && inst_valid && (consume_len != 3'd0);
    ret_len   = 3'd0;
    if (do_retire) begin
      if ({{(CW-3){1'b0}}, consume_len} > count_q) begin
        ret_len = count_q[2:0];
      end else begin
        ret_len = consume_len;
      end
    end
  end

  // Fetching only starts with room for a whole word, and retires only free
  // space, so an ack can never overflow the buffer.
  always_comb begin
    count_next = count_q + {{(CW-3){1'b0}}, wr_len} - {{(CW-3){1'b0}}, ret_len};
    space_ok   = (count_next <= CW'(DEPTH - 4));
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (space_ok) state_next = FETCH;
      FETCH:   if (do_write && !space_ok) state_next = IDLE;
      default: state_next = FETCH;
    endcase
    if (flush) begin
      state_next = FETCH;
    end
  end

  // FSM: outputs
  always_comb begin
    bus.fetch_req  = (state == FETCH);
    bus.fetch_addr = addr_q;
  end

  // Pointers, count, program counter and fetch address
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      pc_q    <= RESET_PC;
      addr_q  <= {RESET_PC[31:2], 2'b00};
      skip_q  <= RESET_PC[1:0];
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      pc_q    <= flush_addr;
      addr_q  <= {flush_addr[31:2], 2'b00};
      skip_q  <= flush_addr[1:0];
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + PW'(wr_len);
        addr_q <= addr_q + 32'd4;
        skip_q <= 2'd0;
      end
      if (do_retire) begin
        rd_ptr <= rd_ptr + PW'(ret_len);
        pc_q   <= pc_q + {29'd0, ret_len};
      end
      count_q <= count_next;
    end
  end

  // Byte storage; contents are left as-is on reset and flush since count gates them.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (i >= int'(skip_q)) begin
          mem[wr_ptr + PW'(i) - PW'(skip_q)] <= bus.fetch_data[8*i +: 8];
        end
      end
    end
  end

  // Head window: byte k of the window sits at rd_ptr + k
  always_comb begin
    inst = '0;
    for (int k = 0; k < 6; k++) begin
      if (CW'(k) < count_q) begin
        inst[8*(5-k) +: 8] = mem[rd_ptr + PW'(k)];
      end
    end
  end

  assign inst_valid = (count_q >= CW'(6));
  assign inst_pc    = pc_q;
  assign count      = count_q;

endmodule

// File: tb/tb_v60_prefetch_queue.sv
// tb/tb_v60_prefetch_queue.sv - directed self-checking bench for v60_prefetch_queue

module tb_v60_prefetch_queue;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [31:0] flush_addr;
  logic [47:0] inst;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic        consume;
  logic [2:0]  consume_len;
  logic [4:0]  count;

  int errors = 0;
  int checks = 0;

  v60_prefetch_queue_if bus ();

  v60_prefetch_queue #(.DEPTH(16), .RESET_PC(32'hFFFF_FFF0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .flush       (flush),
    .flush_addr  (flush_addr),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .inst_pc     (inst_pc),
    .consume     (consume),
    .consume_len (consume_len),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus, advance past the edge, then release pulses.
  task automatic step(input logic a, input logic [31:0] d, input logic c, input logic [2:0] l,
                      input logic f, input logic [31:0] fa);
    bus.fetch_ack  = a;
    bus.fetch_data = d;
    consume        = c;
    consume_len    = l;
    flush          = f;
    flush_addr     = fa;
    @(posedge clk);
    #1;
    bus.fetch_ack = 1'b0;
    consume       = 1'b0;
    consume_len   = 3'd0;
    flush         = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(1'b1, 32'hAABBCCDD, 1'b1, 3'd3, 1'b1, 32'h0000_1234);
    step(1'b0, 32'h0, 1'b0, 3'd0, 1'b0, 32'h0);
    rst_n = 1'b1;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
    checks++; if (inst !== 48'h0) begin errors++; $display("FAIL reset_inst got=%h exp=0", inst); end
    checks++; if (inst_pc !== 32'hFFFF_FFF0) begin errors++; $display("FAIL reset_pc got=%h exp=fffffff0", inst_pc); end
    checks++; if (bus.fetch_addr !== 32'hFFFF_FFF0) begin errors++; $display("FAIL reset_addr got=%h exp=fffffff0", bus.fetch_addr); end
    checks++; if (bus.fetch_req !== 1'b1) begin errors++; $display("FAIL reset_req got=%b exp=1", bus.fetch_req); end
  endtask

  task automatic test_basic();
    step(1'b1, 32'h0302_0100, 1'b0, 3'd0, 1'b0, 32'h0);
    checks++; if (count !== 5'd4) begin errors++; $display("FAIL basic_count1 got=%0d exp=4", count); end
    checks++; if (bus.fetch_addr !== 32'hFFFF_FFF4) begin errors++; $display("FAIL basic_addr1 got=%h exp=fffffff4", bus.fetch_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL basic_valid1 got=%b exp=0", inst_valid); end
    step(1'b1, 32'h0706_0504, 1'b0, 3'd0, 1'b0, 32'h0);
    checks++; if (inst !== 48'h0001_0203_0405) begin errors++; $display("FAIL basic_inst got=%h exp=000102030405", inst); end
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL basic_valid2 got=%b exp=1", inst_valid); end
    checks++; if (inst_pc !== 32'hFFFF_FFF0) begin errors++; $display("FAIL basic_pc got=%h exp=fffffff0", inst_pc); end
    checks++; if (count !== 5'd8) begin errors++; $display("FAIL basic_count2 got=%0d exp=8", count); end
  endtask

  task automatic test_fill();
    step(1'b1, 32'h0B0A_0908, 1'b0, 3'd0, 1'b0, 32'h0);
    checks++; if (bus.fetch_req !== 1'b1) begin errors++; $display("FAIL fill_req12 got=%b exp=1", bus.fetch_req); end
    step(1'b1, 32'h0F0E_0D0C, 1'b0, 3'd0, 1'b0, 32'h0);
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_count16 got=%0d exp=16", count); end
    checks++; if (bus.fetch_req !== 1'b0) begin errors++; $display("FAIL fill_req_drop got=%b exp=0", bus.fetch_req); end
    checks++; if (bus.fetch_addr !== 32'h0000_0000) begin errors++; $display("FAIL fill_addr_wrap got=%h exp=00000000", bus.fetch_addr); end
    step(1'b0, 32'h0, 1'b0, 3'd0, 1'b0, 32'h0);
    checks++; if (bus.fetch_req !== 1'b0) begin errors++; $display("FAIL fill_req_idle got=%b exp=0", bus.fetch_req); end
    step(1'b0, 32'h0, 1'b1, 3'd4, 1'b0, 32'h0);
    checks++; if (count !== 5'd12) begin errors++; $display("FAIL fill_count12 got=%0d exp=12", count); end
    checks++; if (bus.fetch_req !== 1'b1) begin errors++; $display("FAIL fill_req_rise got=%b exp=1", bus.fetch_req); end
    checks++; if (inst_pc !== 32'hFFFF_FFF4) begin errors++; $display("FAIL fill_pc got=%h exp=fffffff4", inst_pc); end
    checks++; if (inst !== 48'h0405_0607_0809) begin errors++; $display("FAIL fill_inst got=%h exp=040506070809", inst); end
  endtask

  task automatic test_ack_consume();
    step(1'b0, 32'h0, 1'b1, 3'd4, 1'b0, 32'h0);
    checks++; if (count !== 5'd8) begin errors++; $display("FAIL ac_count8 got=%0d exp=8", count); end
    checks++; if (inst !== 48'h0809_0A0B_0C0D) begin errors++; $display("FAIL ac_inst8 got=%h exp=08090a0b0c0d", inst); end
    step(1'b1, 32'h1312_1110, 1'b1, 3'd3, 1'b0, 32'h0);
    checks++; if (count !== 5'd9) begin errors++; $display("FAIL ac_count9 got=%0d exp=9", count); end
    checks++; if (inst_pc !== 32'hFFFF_FFFB) begin errors++; $display("FAIL ac_pc got=%h exp=fffffffb", inst_pc); end
    checks++; if (inst !== 48'h0B0C_0D0E_0F10) begin errors++; $display("FAIL ac_inst_wrap got=%h exp=0b0c0d0e0f10", inst); end
    checks++; if (bus.fetch_addr !== 32'h0000_0004) begin errors++; $display("FAIL ac_addr got=%h exp=00000004", bus.fetch_addr); end
    step(1'b0, 32'h0, 1'b1, 3'd6, 1'b0, 32'h0);
    checks++; if (inst_pc !== 32'h0000_0001) begin errors++; $display("FAIL ac_pc_wrap got=%h exp=00000001", inst_pc); end
    checks++; if (inst !== 48'h1112_1300_0000) begin errors++; $display("FAIL ac_inst_partial got=%h exp=111213000000", inst); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL ac_valid got=%b exp=0", inst_valid); end
    step(1'b0, 32'h0, 1'b1, 3'd3, 1'b0, 32'h0);
    checks++; if (count !== 5'd3) begin errors++; $display("FAIL ac_consume_invalid got=%0d exp=3", count); end
    checks++; if (inst_pc !== 32'h0000_0001) begin errors++; $display("FAIL ac_pc_hold got=%h exp=00000001", inst_pc); end
  endtask

  task automatic test_consume_max();
    step(1'b1, 32'h1716_1514, 1'b0, 3'd0, 1'b0, 32'h0);
    checks++; if (count !== 5'd7) begin errors++; $display("FAIL cm_count7 got=%0d exp=7", count); end
    step(1'b0, 32'h0, 1'b1, 3'd0, 1'b0, 32'h0);
    checks++; if (count !== 5'd7) begin errors++; $display("FAIL cm_len0 got=%0d exp=7", count); end
    step(1'b0, 32'h0, 1'b1, 3'd1, 1'b0, 32'h0);
    checks++; if (count !== 5'd6) begin errors++; $display("FAIL cm_count6 got=%0d exp=6", count); end
    checks++; if (inst !== 48'h1213_1415_1617) begin errors++; $display("FAIL cm_inst got=%h exp=121314151617", inst); end
    step(1'b0, 32'h0, 1'b1, 3'd7, 1'b0, 32'h0);
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL cm_count0 got=%0d exp=0", count); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL cm_valid got=%b exp=0", inst_valid); end
    checks++; if (inst_pc !== 32'h0000_0008) begin errors++; $display("FAIL cm_pc got=%h exp=00000008", inst_pc); end
    checks++; if (inst !== 48'h0) begin errors++; $display("FAIL cm_inst0 got=%h exp=0", inst); end
  endtask

  task automatic test_flush();
    step(1'b0, 32'h0, 1'b0, 3'd0, 1'b1, 32'h0000_1003);
    checks++; if (bus.fetch_addr !== 32'h0000_1000) begin errors++; $display("FAIL fl_addr got=%h exp=00001000", bus.fetch_addr); end
    checks++; if (inst_pc !== 32'h0000_1003) begin errors++; $display("FAIL fl_pc got=%h exp=00001003", inst_pc); end
    checks++; if (bus.fetch_req !== 1'b1) begin errors++; $display("FAIL fl_req got=%b exp=1", bus.fetch_req); end
    step(1'b1, 32'hDDCC_BBAA, 1'b0, 3'd0, 1'b0, 32'h0);
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL fl_skip_count got=%0d exp=1", count); end
    step(1'b1, 32'h4433_2211, 1'b0, 3'd0, 1'b0, 32'h0);
    checks++; if (count !== 5'd5) begin errors++; $display("FAIL fl_count5 got=%0d exp=5", count); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL fl_valid got=%b exp=0", inst_valid); end
    checks++; if (bus.fetch_addr !== 32'h0000_1008) begin errors++; $display("FAIL fl_addr2 got=%h exp=00001008", bus.fetch_addr); end
    step(1'b1, 32'h8877_6655, 1'b0, 3'd0, 1'b0, 32'h0);
    checks++; if (inst !== 48'hDD11_2233_4455) begin errors++; $display("FAIL fl_inst got=%h exp=dd1122334455", inst); end
    checks++; if (inst_pc !== 32'h0000_1003) begin errors++; $display("FAIL fl_pc2 got=%h exp=00001003", inst_pc); end
    checks++; if (count !== 5'd9) begin errors++; $display("FAIL fl_count9 got=%0d exp=9", count); end
  endtask

  task automatic test_flush_collide();
    step(1'b1, 32'hFFFF_FFFF, 1'b1, 3'd3, 1'b1, 32'h0000_2000);
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL fc_count got=%0d exp=0", count); end
    checks++; if (bus.fetch_addr !== 32'h0000_2000) begin errors++; $display("FAIL fc_addr got=%h exp=00002000", bus.fetch_addr); end
    checks++; if (inst_pc !== 32'h0000_2000) begin errors++; $display("FAIL fc_pc got=%h exp=00002000", inst_pc); end
    checks++; if (bus.fetch_req !== 1'b1) begin errors++; $display("FAIL fc_req got=%b exp=1", bus.fetch_req); end
    checks++; if (inst !== 48'h0) begin errors++; $display("FAIL fc_inst got=%h exp=0", inst); end
    step(1'b1, 32'h0302_0100, 1'b0, 3'd0, 1'b0, 32'h0);
    checks++; if (count !== 5'd4) begin errors++; $display("FAIL fc_count4 got=%0d exp=4", count); end
    checks++; if (inst !== 48'h0001_0203_0000) begin errors++; $display("FAIL fc_inst4 got=%h exp=000102030000", inst); end
    checks++; if (bus.fetch_addr !== 32'h0000_2004) begin errors++; $display("FAIL fc_addr2 got=%h exp=00002004", bus.fetch_addr); end
  endtask

  initial begin
    rst_n          = 1'b0;
    flush          = 1'b0;
    flush_addr     = 32'h0;
    consume        = 1'b0;
    consume_len    = 3'd0;
    bus.fetch_ack  = 1'b0;
    bus.fetch_data = 32'h0;
    test_reset();
    test_basic();
    test_fill();
    test_ack_consume();
    test_consume_max();
    test_flush();
    test_flush_collide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
